// File: rtl/sram_fifo_ctrl.sv
// Show-ahead FIFO controller for a dual-port SRAM whose registered read data is the FIFO head.
// Define SRAM_FIFO_LEVEL_EN to add the level_o/full_o occupancy outputs and an overflow assertion.
module sram_fifo_ctrl #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int CNT_W  = $clog2(DEPTH + 2)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [WIDTH-1:0]  in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [WIDTH-1:0]  out_data_o,
   output logic              mem_wen_o,
   output logic [ADDR_W-1:0] mem_waddr_o,
   output logic [WIDTH-1:0]  mem_wdata_o,
   output logic              mem_ren_o,
   output logic [ADDR_W-1:0] mem_raddr_o,
   input  logic [WIDTH-1:0]  mem_rdata_i
`ifdef SRAM_FIFO_LEVEL_EN
  ,output logic [CNT_W-1:0]  level_o,
   output logic              full_o
`endif
);

   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [CNT_W-1:0]  mem_cnt;
   logic              out_vld;
   logic              push;
   logic              pop;
   logic              rd;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready_o depends on registered state only, never on out_ready_i.
   assign in_ready_o = (mem_cnt != CNT_W'(DEPTH));
   assign push       = in_valid_i & in_ready_o;
   assign pop        = out_vld & out_ready_i;
   // Prefetch whenever the output register is empty or being emptied this cycle.
   assign rd         = (mem_cnt != '0) & (~out_vld | out_ready_i);

   assign mem_wen_o   = push;
   assign mem_waddr_o = wptr;
   assign mem_wdata_o = in_data_i;
   assign mem_ren_o   = rd;
   assign mem_raddr_o = rptr;
   assign out_valid_o = out_vld;
   assign out_data_o  = mem_rdata_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wptr    <= '0;
         rptr    <= '0;
         mem_cnt <= '0;
         out_vld <= 1'b0;
      end else begin
         if (push) begin
            wptr <= (wptr == ADDR_W'(DEPTH - 1)) ? '0 : wptr + ADDR_W'(1);
         end
         if (rd) begin
            rptr <= (rptr == ADDR_W'(DEPTH - 1)) ? '0 : rptr + ADDR_W'(1);
         end
         case ({push, rd})
            2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
            2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
            default: mem_cnt <= mem_cnt;
         endcase
         if (rd) begin
            out_vld <= 1'b1;
         end else if (pop) begin
            out_vld <= 1'b0;
         end
      end
   end

`ifdef SRAM_FIFO_LEVEL_EN
   assign level_o = mem_cnt + CNT_W'(out_vld);
   assign full_o  = (level_o == CNT_W'(DEPTH + 1));

`ifndef SYNTHESIS
   push_never_when_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(push && (mem_cnt == CNT_W'(DEPTH))));
`endif
`endif

endmodule
